bus_crossbar_rr: RTL
====================

BUS_CROSSBAR_RR -- requirements
Module: bus_crossbar_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of master ports (legal range 1..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 2, number of slave ports (legal range 1..8).
REQ-003 SHALL have parameter SEL_NUM_BITS, default {5'd1,5'd1}, packed 5-bit decode width per slave; slave s uses bits [5s+4:5s].
REQ-004 SHALL have parameter SEL_VAL, default {30'd1<<29,30'd0}, packed 30-bit match value per slave; slave s uses bits [30s+29:30s].
REQ-005 i_Clk  in  1  single clock; all state on rising edge.
REQ-006 i_Rst  in  1  asynchronous, active-high reset.
REQ-007 i_AVIn_Addr  in  30*NUM_MASTERS  word addresses, master m at [30m+:30].
REQ-008 i_AVIn_ByteEn  in  4*NUM_MASTERS  byte enables.
REQ-009 i_AVIn_Read / i_AVIn_Write  in  NUM_MASTERS each  read and write strobes.
REQ-010 i_AVIn_WriteData  in  32*NUM_MASTERS  write data; o_AVIn_ReadData  out  32*NUM_MASTERS  read data.
REQ-011 o_AVIn_WaitRequest  out  NUM_MASTERS  stall to master.
REQ-012 o_AVOut_Addr/ByteEn/Read/Write/WriteData  out  30/4/1/1/32 x NUM_SLAVES  slave-side request.
REQ-013 i_AVOut_ReadData  in  32*NUM_SLAVES; i_AVOut_WaitRequest  in  NUM_SLAVES  slave response.
REQ-014 o_DecodeErr  out  1  one-cycle pulse on unmapped access; o_ErrAddr  out  30  last unmapped address.

Function
REQ-015 Decode: master m targets slave s when Addr[29:30-n]==SEL_VAL_s[29:30-n], n=SEL_NUM_BITS_s; n=0 matches all; lowest matching s wins; no match = unmapped.
REQ-016 Request = Read|Write; Read and Write both high is illegal, treated as Write.
REQ-017 Per slave, FSM IDLE/BUSY with round-robin pointer LastGnt (last master served).
REQ-018 IDLE: among requesters, grant first index after LastGnt (wrapping); slave outputs driven from granted master the same cycle (zero added request latency).
REQ-019 IDLE, granted, i_AVOut_WaitRequest=0: transfer completes, LastGnt<=granted, stay IDLE.
REQ-020 IDLE, granted, i_AVOut_WaitRequest=1: register Owner<=granted, go BUSY; grant held regardless of other requests.
REQ-021 BUSY: forward Owner only; on WaitRequest=0 complete, LastGnt<=Owner, go IDLE; if Owner drops request, go IDLE next cycle, LastGnt unchanged.
REQ-022 Slave with no grant: Read=Write=0; Addr, ByteEn, WriteData=0.
REQ-023 o_AVIn_WaitRequest[m]=granted slave's WaitRequest when m granted, else 1 while requesting, else 0.
REQ-024 Read data latency fixed at one cycle: on completed read, register RdSrc[m]; next cycle o_AVIn_ReadData[m]=i_AVOut_ReadData[RdSrc]; otherwise 0.
REQ-025 Back-to-back reads from one master to different slaves SHALL each return correct data in consecutive cycles.
REQ-026 Masters targeting different slaves proceed concurrently, no interaction.

Reset
REQ-027 During i_Rst: all FSMs IDLE, LastGnt=NUM_MASTERS-1 (master 0 first), RdSrc cleared, no read data valid, o_DecodeErr=0, o_ErrAddr=0.
REQ-028 Reset mid-BUSY SHALL abort the transfer; all slave strobes low immediately (asynchronous), o_AVIn_ReadData=0.

Configuration
REQ-029 Macro XBAR_DECODE_ERR_EN defined: internal default slave accepts unmapped accesses in one cycle (WaitRequest=0), reads return 32'hDEADBEEF next cycle, writes discarded, o_DecodeErr pulses, o_ErrAddr latches address.
REQ-030 Macro undefined: unmapped accesses hold WaitRequest=1 indefinitely; o_DecodeErr and o_ErrAddr tied 0.

Verification
REQ-031 M0 and M1 read slave 0 same cycle, WaitRequest=0 after reset -> M0 completes cycle 0, M1 cycle 1, data each one cycle later.
REQ-032 M0 holds slave 1 with WaitRequest=1 for 3 cycles while M1 requests slave 1 -> M1 waitrequest=1 throughout, granted the cycle after M0 completes.
REQ-033 M0 to slave 0, M1 to slave 1 simultaneously, 0xA5A5A5A5 / 0x5A5A5A5A readdata -> both complete cycle 0, correct data cycle 1.
REQ-034 NUM_MASTERS=3, all three continuously request slave 0 -> grant order 0,1,2,0,1,2.
REQ-035 With XBAR_DECODE_ERR_EN, read unmapped 30'h3FFFFFFF -> waitrequest 0, data 32'hDEADBEEF next cycle, o_DecodeErr one pulse, o_ErrAddr=30'h3FFFFFFF.
REQ-036 i_Rst asserted during BUSY -> slave Read/Write drop same cycle; after release, master 0 wins first contested request.

Source files
------------

// File: rtl/bus_crossbar_rr.sv
// Multi-master / multi-slave Avalon-style crossbar with per-slave round-robin arbitration.
// Optional internal default slave for unmapped accesses: define XBAR_DECODE_ERR_EN.
module bus_crossbar_rr #(
    parameter int unsigned                  NUM_MASTERS  = 2,
    parameter int unsigned                  NUM_SLAVES   = 2,
    parameter logic [5*NUM_SLAVES-1:0]      SEL_NUM_BITS = {5'd1, 5'd1},
    parameter logic [30*NUM_SLAVES-1:0]     SEL_VAL      = {30'd1 << 29, 30'd0}
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic [30*NUM_MASTERS-1:0]   i_AVIn_Addr,
    input  logic [4*NUM_MASTERS-1:0]    i_AVIn_ByteEn,
    input  logic [NUM_MASTERS-1:0]      i_AVIn_Read,
    input  logic [NUM_MASTERS-1:0]      i_AVIn_Write,
    input  logic [32*NUM_MASTERS-1:0]   i_AVIn_WriteData,
    output logic [32*NUM_MASTERS-1:0]   o_AVIn_ReadData,
    output logic [NUM_MASTERS-1:0]      o_AVIn_WaitRequest,
    output logic [30*NUM_SLAVES-1:0]    o_AVOut_Addr,
    output logic [4*NUM_SLAVES-1:0]     o_AVOut_ByteEn,
    output logic [NUM_SLAVES-1:0]       o_AVOut_Read,
    output logic [NUM_SLAVES-1:0]       o_AVOut_Write,
    output logic [32*NUM_SLAVES-1:0]    o_AVOut_WriteData,
    input  logic [32*NUM_SLAVES-1:0]    i_AVOut_ReadData,
    input  logic [NUM_SLAVES-1:0]       i_AVOut_WaitRequest,
    output logic                        o_DecodeErr,
    output logic [29:0]                 o_ErrAddr
);

    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} slv_state_e;

    // Mask selecting address bits [29:30-n]; n = 0 yields an empty mask (match all).
    function automatic logic [29:0] sel_mask(input logic [4:0] n);
        logic [29:0] mask;
        mask = '0;
        for (int i = 0; i < 30; i++) begin
            if (int'(n) > 29 - i) mask[i] = 1'b1;
        end
        return mask;
    endfunction

    logic [NUM_MASTERS-1:0] mst_req, mst_rd, mst_wr, mst_hit;
    logic [SW-1:0]          mst_slv_sel [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] slv_req     [NUM_SLAVES];

    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            mst_wr[m]      = i_AVIn_Write[m];
            mst_rd[m]      = i_AVIn_Read[m] & ~i_AVIn_Write[m];
            mst_req[m]     = i_AVIn_Read[m] | i_AVIn_Write[m];
            mst_hit[m]     = 1'b0;
            mst_slv_sel[m] = '0;
            // Descending scan so the lowest matching slave index wins.
            for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
                if (((i_AVIn_Addr[30*m +: 30] ^ SEL_VAL[30*s +: 30]) &
                     sel_mask(SEL_NUM_BITS[5*s +: 5])) == '0) begin
                    mst_hit[m]     = 1'b1;
                    mst_slv_sel[m] = SW'(s);
                end
            end
        end
        for (int s = 0; s < NUM_SLAVES; s++) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                slv_req[s][m] = mst_req[m] & mst_hit[m] & (mst_slv_sel[m] == SW'(s));
            end
        end
    end

    slv_state_e             state_q    [NUM_SLAVES];
    slv_state_e             state_d    [NUM_SLAVES];
    logic [MW-1:0]          last_gnt_q [NUM_SLAVES];
    logic [MW-1:0]          last_gnt_d [NUM_SLAVES];
    logic [MW-1:0]          owner_q    [NUM_SLAVES];
    logic [MW-1:0]          owner_d    [NUM_SLAVES];
    logic [NUM_SLAVES-1:0]  gnt_vld;
    logic [MW-1:0]          gnt_idx    [NUM_SLAVES];
    logic [MW-1:0]          cand;

    always_comb begin
        cand = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            state_d[s]    = state_q[s];
            last_gnt_d[s] = last_gnt_q[s];
            owner_d[s]    = owner_q[s];
            gnt_vld[s]    = 1'b0;
            gnt_idx[s]    = '0;
            case (state_q[s])
                StIdle: begin
                    for (int k = 1; k <= NUM_MASTERS; k++) begin
                        cand = MW'((int'(last_gnt_q[s]) + k) % NUM_MASTERS);
                        if (!gnt_vld[s] && slv_req[s][cand]) begin
                            gnt_vld[s] = 1'b1;
                            gnt_idx[s] = cand;
                        end
                    end
                    if (gnt_vld[s]) begin
                        if (i_AVOut_WaitRequest[s]) begin
                            owner_d[s] = gnt_idx[s];
                            state_d[s] = StBusy;
                        end else begin
                            last_gnt_d[s] = gnt_idx[s];
                        end
                    end
                end
                StBusy: begin
                    if (slv_req[s][owner_q[s]]) begin
                        gnt_vld[s] = 1'b1;
                        gnt_idx[s] = owner_q[s];
                        if (!i_AVOut_WaitRequest[s]) begin
                            last_gnt_d[s] = owner_q[s];
                            state_d[s]    = StIdle;
                        end
                    end else begin
                        state_d[s] = StIdle;
                    end
                end
                default: state_d[s] = StIdle;
            endcase
            // Async reset must drop slave strobes combinationally, not at the next edge.
            if (i_Rst) gnt_vld[s] = 1'b0;
        end
    end

    logic [NUM_MASTERS-1:0] mst_gnt, mst_swait;
    logic [SW-1:0]          mst_slv  [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] rd_vld_d, rd_vld_q;
    logic [SW-1:0]          rd_src_d [NUM_MASTERS];
    logic [SW-1:0]          rd_src_q [NUM_MASTERS];
`ifdef XBAR_DECODE_ERR_EN
    logic [NUM_MASTERS-1:0] err_acc, rd_err_d, rd_err_q;
    logic                   decode_err_d, decode_err_q;
    logic [29:0]            err_addr_d, err_addr_q;
`endif

    always_comb begin
        o_AVOut_Addr      = '0;
        o_AVOut_ByteEn    = '0;
        o_AVOut_Read      = '0;
        o_AVOut_Write     = '0;
        o_AVOut_WriteData = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (gnt_vld[s] && gnt_idx[s] == MW'(m)) begin
                    o_AVOut_Addr[30*s +: 30]      = i_AVIn_Addr[30*m +: 30];
                    o_AVOut_ByteEn[4*s +: 4]      = i_AVIn_ByteEn[4*m +: 4];
                    o_AVOut_Read[s]               = mst_rd[m];
                    o_AVOut_Write[s]              = mst_wr[m];
                    o_AVOut_WriteData[32*s +: 32] = i_AVIn_WriteData[32*m +: 32];
                end
            end
        end
    end

    always_comb begin
`ifdef XBAR_DECODE_ERR_EN
        decode_err_d = 1'b0;
        err_addr_d   = err_addr_q;
`endif
        for (int m = 0; m < NUM_MASTERS; m++) begin
            mst_gnt[m]   = 1'b0;
            mst_swait[m] = 1'b0;
            mst_slv[m]   = '0;
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (gnt_vld[s] && gnt_idx[s] == MW'(m)) begin
                    mst_gnt[m]   = 1'b1;
                    mst_swait[m] = i_AVOut_WaitRequest[s];
                    mst_slv[m]   = SW'(s);
                end
            end
            rd_vld_d[m] = mst_gnt[m] & ~mst_swait[m] & mst_rd[m];
            rd_src_d[m] = mst_slv[m];
            if (mst_gnt[m]) begin
                o_AVIn_WaitRequest[m] = mst_swait[m];
            end else begin
                o_AVIn_WaitRequest[m] = mst_req[m];
            end
`ifdef XBAR_DECODE_ERR_EN
            // The default slave accepts every unmapped access immediately; no arbitration.
            err_acc[m]  = mst_req[m] & ~mst_hit[m] & ~i_Rst;
            rd_err_d[m] = err_acc[m] & mst_rd[m];
            if (err_acc[m]) o_AVIn_WaitRequest[m] = 1'b0;
`endif
        end
`ifdef XBAR_DECODE_ERR_EN
        for (int m = NUM_MASTERS - 1; m >= 0; m--) begin
            if (err_acc[m]) begin
                decode_err_d = 1'b1;
                err_addr_d   = i_AVIn_Addr[30*m +: 30];
            end
        end
`endif
    end

    always_comb begin
        o_AVIn_ReadData = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (rd_vld_q[m] && rd_src_q[m] == SW'(s)) begin
                    o_AVIn_ReadData[32*m +: 32] = i_AVOut_ReadData[32*s +: 32];
                end
            end
`ifdef XBAR_DECODE_ERR_EN
            if (rd_err_q[m]) o_AVIn_ReadData[32*m +: 32] = 32'hDEADBEEF;
`endif
        end
    end

`ifdef XBAR_DECODE_ERR_EN
    assign o_DecodeErr = decode_err_q;
    assign o_ErrAddr   = err_addr_q;
`else
    assign o_DecodeErr = 1'b0;
    assign o_ErrAddr   = '0;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                state_q[s]    <= StIdle;
                last_gnt_q[s] <= MW'(NUM_MASTERS - 1);
                owner_q[s]    <= '0;
            end
            for (int m = 0; m < NUM_MASTERS; m++) begin
                rd_src_q[m] <= '0;
            end
            rd_vld_q <= '0;
`ifdef XBAR_DECODE_ERR_EN
            rd_err_q     <= '0;
            decode_err_q <= 1'b0;
            err_addr_q   <= '0;
`endif
        end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                state_q[s]    <= state_d[s];
                last_gnt_q[s] <= last_gnt_d[s];
                owner_q[s]    <= owner_d[s];
            end
            for (int m = 0; m < NUM_MASTERS; m++) begin
                rd_src_q[m] <= rd_src_d[m];
            end
            rd_vld_q <= rd_vld_d;
`ifdef XBAR_DECODE_ERR_EN
            rd_err_q     <= rd_err_d;
            decode_err_q <= decode_err_d;
            err_addr_q   <= err_addr_d;
`endif
        end
    end

endmodule
